// File: rtl/tl_copy_engine_pkg.sv
// ----------------------------------------------------------------------------
// tl_copy_engine_pkg
// Shared TileLink-UL definitions for the copy engine and its interface:
//   - A/D channel opcode encodings (Get, PutFullData, AccessAck, AccessAckData)
//   - tilelink_a : request channel driven by the initiator
//   - tilelink_d : response channel driven by the responder
//   - small helpers for idle A-channel value and word alignment
// ----------------------------------------------------------------------------
package tl_copy_engine_pkg;

    // A-channel and D-channel opcodes share encodings, so keep them distinct by name.
    localparam logic [2:0] TL_PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam logic [2:0] TL_SIZE_WORD = 3'd2;   // log2(4 bytes)
    localparam logic [3:0] TL_MASK_WORD = 4'hF;

    // a_ready travels with the request: it tells the responder we always take D beats.
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        a_ready;
    } tilelink_a;

    // d_ready travels with the response: it tells the initiator an A beat is taken.
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [31:0] d_data;
        logic        d_error;
        logic        d_ready;
    } tilelink_d;

    function automatic tilelink_a tla_idle();
        tilelink_a t;
        t         = '0;
        t.a_ready = 1'b1;
        return t;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/tl_copy_engine_if.sv
// ----------------------------------------------------------------------------
// tl_copy_engine_if
// One TileLink-UL A/D port pair.
//   bus_tla  : request channel  (master drives, slave observes)
//   tick_tld : response channel (slave drives, master observes)
// ----------------------------------------------------------------------------
interface tl_copy_engine_if;
    import tl_copy_engine_pkg::*;

    tilelink_a bus_tla;
    tilelink_d tick_tld;

    modport master (output bus_tla, input  tick_tld);
    modport slave  (input  bus_tla, output tick_tld);
endinterface

// File: rtl/tl_copy_engine.sv
// ----------------------------------------------------------------------------
// tl_copy_engine
// TileLink-UL initiator that copies len 32-bit words from src_addr to
// dst_addr, one Get followed by one PutFullData per word, with a single
// request outstanding. Stops on a D-channel error or a response timeout.
// Ports:
//   clock, reset_n        : clock and synchronous active-low reset
//   start                 : begin a copy (only looked at in IDLE)
//   src_addr, dst_addr    : byte addresses of first words; bits [1:0] ignored
//   len                   : word count, 0 legal
//   busy, done, error     : status (done one-cycle pulse, error sticky)
//   tl (master)           : bus_tla request out, tick_tld response in
// Parameter:
//   timeout_cycles        : max wait for d_valid after an A beat; 0 = never
// ----------------------------------------------------------------------------
module tl_copy_engine
    import tl_copy_engine_pkg::*;
#(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [15:0]       len,
    output logic              busy,
    output logic              done,
    output logic              error,
    tl_copy_engine_if.master  tl
);

    localparam int unsigned WAIT_W = (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    // Counter value at which one more silent cycle means the wait has expired.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((timeout_cycles == 0) ? 0 : timeout_cycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT, ST_DONE, ST_ERR
    } state_e;

    state_e            r_state, w_next_state;
    logic [31:0]       r_src, w_src;
    logic [31:0]       r_dst, w_dst;
    logic [15:0]       r_remaining, w_remaining;
    logic [31:0]       r_data, w_data;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_error, w_error;
    tilelink_a         r_tla, w_tla;

    logic              w_d_ok;
    logic              w_d_err;
    logic              w_timeout;

    assign w_d_ok    = tl.tick_tld.d_valid & ~tl.tick_tld.d_error;
    assign w_d_err   = tl.tick_tld.d_valid &  tl.tick_tld.d_error;
    assign w_timeout = (timeout_cycles != 0) && (r_wait_cnt == WAIT_LAST);

    // Next state, next datapath values and next registered outputs.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        w_next_state = r_state;
        w_src        = r_src;
        w_dst        = r_dst;
        w_remaining  = r_remaining;
        w_data       = r_data;
        w_wait_cnt   = r_wait_cnt;
        w_error      = r_error;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_error = 1'b0;
                    if (len != 16'd0) begin
                        w_next_state = ST_RD_REQ;
                        w_src        = word_align(src_addr);
                        w_dst        = word_align(dst_addr);
                        w_remaining  = len;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_RD_REQ: begin
                if (tl.tick_tld.d_ready) begin
                    w_next_state = ST_RD_WAIT;
                    w_wait_cnt   = '0;
                end
            end
            ST_RD_WAIT: begin
                if (w_d_err) begin
                    w_next_state = ST_ERR;
                end else if (w_d_ok && tl.tick_tld.d_opcode == TL_ACCESS_ACK_DATA) begin
                    w_next_state = ST_WR_REQ;
                    w_data       = tl.tick_tld.d_data;
                end else if (w_timeout) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_wait_cnt = r_wait_cnt + 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (tl.tick_tld.d_ready) begin
                    w_next_state = ST_WR_WAIT;
                    w_wait_cnt   = '0;
                end
            end
            ST_WR_WAIT: begin
                if (w_d_err) begin
                    w_next_state = ST_ERR;
                end else if (w_d_ok) begin
                    // Address arithmetic wraps modulo 2^32 by construction.
                    w_src        = r_src + 32'd4;
                    w_dst        = r_dst + 32'd4;
                    w_remaining  = r_remaining - 16'd1;
                    w_next_state = (r_remaining == 16'd1) ? ST_DONE : ST_RD_REQ;
                end else if (w_timeout) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_wait_cnt = r_wait_cnt + 1'b1;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            ST_ERR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase

        if (w_next_state == ST_ERR) begin
            w_error = 1'b1;
        end

        // Outputs are decoded from the next state so they leave a register.
        w_busy = (w_next_state == ST_RD_REQ) || (w_next_state == ST_RD_WAIT) ||
                 (w_next_state == ST_WR_REQ) || (w_next_state == ST_WR_WAIT);
        w_done = (w_next_state == ST_DONE);

        w_tla = tla_idle();
        if (w_next_state == ST_RD_REQ) begin
            w_tla.a_valid   = 1'b1;
            w_tla.a_opcode  = TL_GET;
            w_tla.a_size    = TL_SIZE_WORD;
            w_tla.a_mask    = TL_MASK_WORD;
            w_tla.a_address = w_src;
        end else if (w_next_state == ST_WR_REQ) begin
            w_tla.a_valid   = 1'b1;
            w_tla.a_opcode  = TL_PUT_FULL_DATA;
            w_tla.a_size    = TL_SIZE_WORD;
            w_tla.a_mask    = TL_MASK_WORD;
            w_tla.a_address = w_dst;
            w_tla.a_data    = w_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: every register here is reset; there is no memory array whose reset would be costly.
            r_state     <= ST_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_wait_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_tla       <= tla_idle();
        end else begin
            r_state     <= w_next_state;
            r_src       <= w_src;
            r_dst       <= w_dst;
            r_remaining <= w_remaining;
            r_data      <= w_data;
            r_wait_cnt  <= w_wait_cnt;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_error     <= w_error;
            r_tla       <= w_tla;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign tl.bus_tla = r_tla;

endmodule

// File: tb/tb_tl_copy_engine.sv
// ----------------------------------------------------------------------------
// tb_tl_copy_engine
// Directed bench for tl_copy_engine. A small block-RAM-like responder
// (addr_mask 32'hF0000000, addr_tag 0) answers accepted beats after a
// configurable latency; Gets read mem_init, Puts write wr_mem.
// ----------------------------------------------------------------------------
module tb_tl_copy_engine;
    import tl_copy_engine_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;

    tl_copy_engine_if tl ();

    tl_copy_engine #(.timeout_cycles(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .tl       (tl)
    );

    always #5 clock = ~clock;

    // ---------------- responder model ----------------
    logic [31:0] mem_init [0:511];
    logic [31:0] wr_mem   [0:511];
    logic        d_ready       = 1'b1;
    logic        map_all       = 1'b0;
    int          resp_lat      = 1;
    int          err_get_index = 0;
    int          get_count     = 0;
    int          put_count     = 0;
    int          pend_cnt      = 0;
    logic [2:0]  pend_op       = '0;
    logic [31:0] pend_data     = '0;
    logic        pend_err      = 1'b0;
    logic [8:0]  w_idx;

    assign w_idx = tl.bus_tla.a_address[10:2];

    always @(posedge clock) begin
        if (tl.bus_tla.a_valid && d_ready &&
            (map_all || tl.bus_tla.a_address[31:28] == 4'h0)) begin
            pend_cnt <= resp_lat;
            if (tl.bus_tla.a_opcode == TL_GET) begin
                get_count <= get_count + 1;
                pend_op   <= TL_ACCESS_ACK_DATA;
                pend_data <= mem_init[w_idx];
                pend_err  <= (get_count + 1 == err_get_index);
            end else begin
                put_count     <= put_count + 1;
                wr_mem[w_idx] <= tl.bus_tla.a_data;
                pend_op       <= TL_ACCESS_ACK;
                pend_data     <= '0;
                pend_err      <= 1'b0;
            end
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    always_comb begin
        tl.tick_tld          = '0;
        tl.tick_tld.d_valid  = (pend_cnt == 1);
        tl.tick_tld.d_opcode = pend_op;
        tl.tick_tld.d_data   = pend_data;
        tl.tick_tld.d_error  = pend_err;
        tl.tick_tld.d_ready  = d_ready;
    end

    // ---------------- checking ----------------
    int n_vectors     = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of the last run_copy.
    int        busy_cycles, done_cnt, done_cyc, av_cycles;
    logic      first_err, end_err, end_busy, timed_out, stable_ok;
    tilelink_a held_tla;

    // Pulse start, then sample every negedge until done or error (bounded),
    // plus two trailing cycles. hold = number of edges d_ready stays low once
    // the first Get appears.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input int hold);
        int hold_left;
        busy_cycles = 0; done_cnt = 0; done_cyc = 0; av_cycles = 0;
        stable_ok = 1'b1; timed_out = 1'b1; hold_left = hold;
        @(negedge clock);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(negedge clock);
        start = 1'b0;
        first_err = error;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (busy) busy_cycles++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (tl.bus_tla.a_valid) av_cycles++;
            if (hold_left > 0 && (tl.bus_tla.a_valid || hold_left < hold)) begin
                if (hold_left == hold) held_tla = tl.bus_tla;
                else if (!(tl.bus_tla.a_valid === 1'b1 &&
                           tl.bus_tla.a_address === held_tla.a_address)) stable_ok = 1'b0;
                d_ready = 1'b0;
                hold_left--;
            end else begin
                d_ready = 1'b1;
            end
            if (done || error) begin timed_out = 1'b0; break; end
            @(negedge clock);
        end
        repeat (2) begin
            @(negedge clock);
            if (busy) busy_cycles++;
            if (done) done_cnt++;
        end
        end_err  = error;
        end_busy = busy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   p0;
        logic found;
        for (int i = 0; i < 512; i++) mem_init[i] = 32'd0;
        mem_init[0] = 32'd11; mem_init[1] = 32'd22;
        mem_init[2] = 32'd33; mem_init[3] = 32'd44;
        mem_init[511] = 32'h55;
        reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_error",   32'(error), 32'd0);
        check("rst_a_valid", 32'(tl.bus_tla.a_valid), 32'd0);
        check("rst_a_ready", 32'(tl.bus_tla.a_ready), 32'd1);
        check("rst_a_addr",  tl.bus_tla.a_address, 32'd0);
        check("rst_a_op",    32'(tl.bus_tla.a_opcode), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // ---- 4-word copy 0x0 -> 0x100 ----
        run_copy(32'h0, 32'h100, 16'd4, 0);
        check("copy4_finished", 32'(timed_out), 32'd0);
        check("copy4_busy",     busy_cycles, 32'd16);
        check("copy4_done_cnt", done_cnt, 32'd1);
        check("copy4_done_cyc", done_cyc, 32'd17);
        check("copy4_error",    32'(end_err), 32'd0);
        check("copy4_w0", wr_mem[9'h40], 32'd11);
        check("copy4_w1", wr_mem[9'h41], 32'd22);
        check("copy4_w2", wr_mem[9'h42], 32'd33);
        check("copy4_w3", wr_mem[9'h43], 32'd44);

        // ---- len = 0 ----
        run_copy(32'h0, 32'h500, 16'd0, 0);
        check("len0_done_cyc", done_cyc, 32'd1);
        check("len0_done_cnt", done_cnt, 32'd1);
        check("len0_busy",     busy_cycles, 32'd0);
        check("len0_a_valid",  av_cycles, 32'd0);

        // ---- d_error on the second Get ----
        p0 = put_count;
        err_get_index = get_count + 2;
        run_copy(32'h0, 32'h180, 16'd4, 0);
        err_get_index = 0;
        check("derr_error",    32'(end_err), 32'd1);
        check("derr_busy",     32'(end_busy), 32'd0);
        check("derr_done_cnt", done_cnt, 32'd0);
        check("derr_busy_cyc", busy_cycles, 32'd6);
        check("derr_puts",     put_count - p0, 32'd1);
        check("derr_w0",       wr_mem[9'h60], 32'd11);

        // ---- d_ready held low 5 edges on first Get; start clears error ----
        run_copy(32'h8, 32'h1C0, 16'd2, 5);
        check("hold_err_clr",  32'(first_err), 32'd0);
        check("hold_stable",   32'(stable_ok), 32'd1);
        check("hold_op",       32'(held_tla.a_opcode), 32'(TL_GET));
        check("hold_size",     32'(held_tla.a_size), 32'd2);
        check("hold_mask",     32'(held_tla.a_mask), 32'hF);
        check("hold_param_src", {21'd0, held_tla.a_param, held_tla.a_source}, 32'd0);
        check("hold_addr",     held_tla.a_address, 32'h8);
        check("hold_busy",     busy_cycles, 32'd13);
        check("hold_done_cnt", done_cnt, 32'd1);
        check("hold_w0",       wr_mem[9'h70], 32'd33);
        check("hold_w1",       wr_mem[9'h71], 32'd44);

        // ---- unmapped source: timeout after 8 wait cycles ----
        run_copy(32'h2000_0000, 32'h200, 16'd1, 0);
        check("tmo_error",    32'(end_err), 32'd1);
        check("tmo_busy_cyc", busy_cycles, 32'd9);
        check("tmo_done_cnt", done_cnt, 32'd0);

        // ---- source address wraps 0xFFFFFFFC -> 0 ----
        map_all = 1'b1;
        run_copy(32'hFFFF_FFFC, 32'h400, 16'd2, 0);
        map_all = 1'b0;
        check("wrap_error",    32'(end_err), 32'd0);
        check("wrap_busy",     busy_cycles, 32'd8);
        check("wrap_done_cnt", done_cnt, 32'd1);
        check("wrap_w0",       wr_mem[9'h100], 32'h55);
        check("wrap_w1",       wr_mem[9'h101], 32'd11);

        // ---- reset during WR_WAIT, stale response, then a fresh copy ----
        resp_lat = 3;
        @(negedge clock);
        start = 1'b1; src_addr = 32'h0; dst_addr = 32'h600; len = 16'd2;
        @(negedge clock);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (tl.bus_tla.a_valid && tl.bus_tla.a_opcode == TL_PUT_FULL_DATA) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid_put_seen", 32'(found), 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("rstmid_busy",    32'(busy), 32'd0);
        check("rstmid_a_valid", 32'(tl.bus_tla.a_valid), 32'd0);
        check("rstmid_a_ready", 32'(tl.bus_tla.a_ready), 32'd1);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check("stale_busy",  32'(busy), 32'd0);
        check("stale_error", 32'(error), 32'd0);
        check("stale_done",  32'(done), 32'd0);
        resp_lat = 1;
        run_copy(32'hB, 32'h302, 16'd2, 0);
        check("after_busy",     busy_cycles, 32'd8);
        check("after_done_cnt", done_cnt, 32'd1);
        check("after_error",    32'(end_err), 32'd0);
        check("after_w0",       wr_mem[9'hC0], 32'd33);
        check("after_w1",       wr_mem[9'hC1], 32'd44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
